// File: rtl/audio_stream_pkg.sv
// Shared types and constants for the audio stream valid/ready/data/last path.
package audio_stream_pkg;

   localparam int DATA_W    = 32;
   localparam int OVF_CNT_W = 16;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              last;
   } beat_t;

endpackage

// File: rtl/audio_frame_packetizer_fifo.sv
// sync_fifo: beat storage for the frame packetizer. Pointers wrap naturally
// (DEPTH is a power of two); occupancy is kept in a separate level counter so
// full and empty are distinguishable without an extra pointer bit.
// The caller guarantees wr_en only when !full || rd_en, and rd_en only when !empty.
module sync_fifo
   import audio_stream_pkg::*;
#(
   parameter int  DEPTH       = 16,
   parameter type beat_type_t = beat_t
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  beat_type_t               wr_beat,
   input  logic                     rd_en,
   output beat_type_t               rd_beat,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

   beat_type_t      mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     level_q, level_d;

   // Storage array; intentionally not reset, the head is masked when empty.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= wr_beat;
      end
   end

   // Next pointer and occupancy values.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd_en) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({wr_en, rd_en})
         2'b10:   level_d = level_q + (AW + 1)'(1);
         2'b01:   level_d = level_q - (AW + 1)'(1);
         default: level_d = level_q;
      endcase
   end

   // Pointer and level registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   assign rd_beat = mem_q[rd_ptr_q];
   assign full    = (level_q == FULL_LVL);
   assign empty   = (level_q == '0);
   assign level   = level_q;

endmodule

// File: rtl/audio_frame_packetizer.sv
// audio_frame_packetizer: buffers strobed ADC samples and emits them as
// fixed-length valid/ready frames with m_last on the final beat.
// Optional: define PACKETIZER_OVF_CNT_EN to add the saturating ovf_count port.
module audio_frame_packetizer
   import audio_stream_pkg::OVF_CNT_W;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int LEN_W  = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     sample_valid,
   input  logic [DATA_W-1:0]        sample_data,
   input  logic [LEN_W-1:0]         frame_len,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [DATA_W-1:0]        m_data,
   output logic                     m_last,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow
`ifdef PACKETIZER_OVF_CNT_EN
   ,
   output logic [OVF_CNT_W-1:0]     ovf_count
`endif
);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              last;
   } beat_w_t;

   logic              full, empty, hs, accept, drop, beat_last;
   logic [LEN_W-1:0]  len_sel, len_eff;
   logic [LEN_W-1:0]  wcnt_q, wcnt_d;
   logic [LEN_W-1:0]  cur_len_q, cur_len_d;
   logic              overflow_q, overflow_d;
   beat_w_t           wr_beat, rd_beat;

   // Acceptance, frame position tagging and sticky overflow.
   // The last tag uses the length latched in this same cycle at frame start,
   // so a 1-beat frame is tagged correctly on its first sample.
   always_comb begin
      hs           = !empty && m_ready;
      accept       = sample_valid && (!full || hs);
      drop         = sample_valid && !accept;
      len_sel      = (frame_len == '0) ? LEN_W'(1) : frame_len;
      len_eff      = (wcnt_q == '0) ? len_sel : cur_len_q;
      beat_last    = (wcnt_q == len_eff - LEN_W'(1));
      wr_beat.data = sample_data;
      wr_beat.last = beat_last;
      wcnt_d       = wcnt_q;
      cur_len_d    = cur_len_q;
      if (accept) begin
         if (wcnt_q == '0) begin
            cur_len_d = len_sel;
         end
         wcnt_d = beat_last ? '0 : wcnt_q + LEN_W'(1);
      end
      overflow_d = overflow_q | drop;
   end

   // Framing and overflow state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wcnt_q     <= '0;
         cur_len_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         wcnt_q     <= wcnt_d;
         cur_len_q  <= cur_len_d;
         overflow_q <= overflow_d;
      end
   end

`ifdef PACKETIZER_OVF_CNT_EN
   logic [OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

   // Saturating count of dropped samples.
   always_comb begin
      ovf_cnt_d = ovf_cnt_q;
      if (drop && (ovf_cnt_q != '1)) begin
         ovf_cnt_d = ovf_cnt_q + OVF_CNT_W'(1);
      end
   end

   // Dropped-sample counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_cnt_q <= '0;
      end else begin
         ovf_cnt_q <= ovf_cnt_d;
      end
   end

   assign ovf_count = ovf_cnt_q;
`endif

   sync_fifo #(
      .DEPTH       (DEPTH),
      .beat_type_t (beat_w_t)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (accept),
      .wr_beat (wr_beat),
      .rd_en   (hs),
      .rd_beat (rd_beat),
      .full    (full),
      .empty   (empty),
      .level   (level)
   );

   assign m_valid  = !empty;
   assign m_data   = empty ? '0 : rd_beat.data;
   assign m_last   = !empty && rd_beat.last;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_audio_frame_packetizer.sv
// Bench for audio_frame_packetizer: directed framing scenarios plus randomized
// strobes and stalls, checked against a queue-based frame model.
module tb_audio_frame_packetizer;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sample_valid = 1'b0;
   logic [31:0] sample_data = '0;
   logic [15:0] frame_len = 16'd1;
   logic        m_ready = 1'b0;
   logic        m_valid;
   logic [31:0] m_data;
   logic        m_last;
   logic [4:0]  level;
   logic        overflow;
`ifdef PACKETIZER_OVF_CNT_EN
   logic [15:0] ovf_count;
`endif

   audio_frame_packetizer #(
      .DATA_W (32),
      .DEPTH  (DEPTH),
      .LEN_W  (16)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_valid (sample_valid),
      .sample_data  (sample_data),
      .frame_len    (frame_len),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .m_last       (m_last),
      .level        (level),
      .overflow     (overflow)
`ifdef PACKETIZER_OVF_CNT_EN
      ,
      .ovf_count    (ovf_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic        last;
   } beat_s;

   beat_s       mq[$];     // expected FIFO contents, head first
   beat_s       log_q[$];  // beats observed at handshakes
   int unsigned mpos, mlen, mcnt;
   logic        movf;
   logic        hold_ok, prev_valid, prev_ready, prev_last;
   logic [31:0] prev_data;
   int          total = 0;
   int          bad = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic observe();
      check("x_on_outputs", 64'($isunknown({m_valid, m_last})), 64'd0);
      check("m_valid", 64'(m_valid), 64'(mq.size() != 0));
      if (mq.size() != 0) begin
         check("m_data", 64'(m_data), 64'(mq[0].data));
         check("m_last", 64'(m_last), 64'(mq[0].last));
      end else begin
         check("m_data_idle", 64'(m_data), 64'd0);
         check("m_last_idle", 64'(m_last), 64'd0);
      end
      check("level", 64'(level), 64'(mq.size()));
      check("overflow", 64'(overflow), 64'(movf));
`ifdef PACKETIZER_OVF_CNT_EN
      check("ovf_count", 64'(ovf_count), 64'(mcnt));
`endif
      if (hold_ok && prev_valid && !prev_ready) begin
         check("hold_valid", 64'(m_valid), 64'd1);
         check("hold_data", 64'(m_data), 64'(prev_data));
         check("hold_last", 64'(m_last), 64'(prev_last));
      end
   endtask

   // One clock: check outputs, drive inputs, advance the frame model.
   task automatic step(input logic sv, input logic [31:0] d, input logic [15:0] fl, input logic rdy);
      logic  hs, acc, lst;
      beat_s b;
      @(negedge clk);
      observe();
      sample_valid = sv;
      sample_data  = d;
      frame_len    = fl;
      m_ready      = rdy;
      hs  = (mq.size() != 0) && rdy;
      acc = sv && ((mq.size() < DEPTH) || hs);
      if (hs) begin
         b.data = m_data;
         b.last = m_last;
         log_q.push_back(b);
         void'(mq.pop_front());
      end
      if (acc) begin
         if (mpos == 0) mlen = (fl == 0) ? 1 : int'(fl);
         lst  = (mpos == mlen - 1);
         mpos = lst ? 0 : mpos + 1;
         b.data = d;
         b.last = lst;
         mq.push_back(b);
      end else if (sv) begin
         movf = 1'b1;
         if (mcnt < 65535) mcnt++;
      end
      prev_valid = m_valid;
      prev_ready = rdy;
      prev_data  = m_data;
      prev_last  = m_last;
      hold_ok    = 1'b1;
   endtask

   // Observe on the next cycle, then park inputs so the model stays in step.
   task automatic peek();
      @(negedge clk);
      sample_valid = 1'b0;
      m_ready      = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_m_valid", 64'(m_valid), 64'd0);
      check("rst_m_data", 64'(m_data), 64'd0);
      check("rst_m_last", 64'(m_last), 64'd0);
      check("rst_level", 64'(level), 64'd0);
      check("rst_overflow", 64'(overflow), 64'd0);
`ifdef PACKETIZER_OVF_CNT_EN
      check("rst_ovf_count", 64'(ovf_count), 64'd0);
`endif
      sample_valid = 1'b0;
      m_ready      = 1'b0;
      mq.delete();
      log_q.delete();
      mpos    = 0;
      mlen    = 1;
      mcnt    = 0;
      movf    = 1'b0;
      hold_ok = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int unsigned strobes, stall, cyc;
      logic        rdy;

      do_reset();

      // Frame length 3, seven back-to-back strobes, sink always ready.
      for (int i = 0; i < 7; i++) step(1'b1, 32'h10 + 32'(i), 16'd3, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 16'd3, 1'b1);
      check("t1_count", 64'(log_q.size()), 64'd7);
      for (int i = 0; i < 7 && i < log_q.size(); i++) begin
         check("t1_data", 64'(log_q[i].data), 64'(32'h10 + 32'(i)));
         check("t1_last", 64'(log_q[i].last), 64'((i == 2) || (i == 5)));
      end

      // Stalled sink, 20 strobes into 16 entries.
      do_reset();
      for (int i = 0; i < 20; i++) step(1'b1, $urandom, 16'd4, 1'b0);
      peek();
      check("t2_level", 64'(level), 64'd16);
      check("t2_overflow", 64'(overflow), 64'd1);
`ifdef PACKETIZER_OVF_CNT_EN
      check("t2_ovf_count", 64'(ovf_count), 64'd4);
`endif
      log_q.delete();
      for (int i = 0; i < 20; i++) step(1'b0, '0, 16'd4, 1'b1);
      check("t2_drain_count", 64'(log_q.size()), 64'd16);
      for (int i = 0; i < 16 && i < log_q.size(); i++)
         check("t2_last", 64'(log_q[i].last), 64'((i % 4) == 3));

      // Full FIFO, strobe coincident with a handshake: accepted, no drop.
      for (int i = 0; i < 16; i++) step(1'b1, $urandom, 16'd4, 1'b0);
      step(1'b1, 32'hCAFE, 16'd4, 1'b1);
      peek();
      check("t3_level", 64'(level), 64'd16);
`ifdef PACKETIZER_OVF_CNT_EN
      check("t3_ovf_count", 64'(ovf_count), 64'd4);
`endif

      // frame_len change mid-frame, then zero length.
      do_reset();
      step(1'b1, 32'hA0, 16'd2, 1'b1);
      for (int i = 1; i < 7; i++) step(1'b1, 32'hA0 + 32'(i), 16'd5, 1'b1);
      for (int i = 7; i < 10; i++) step(1'b1, 32'hA0 + 32'(i), 16'd0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 16'd0, 1'b1);
      check("t4_count", 64'(log_q.size()), 64'd10);
      for (int i = 0; i < 10 && i < log_q.size(); i++)
         check("t4_last", 64'(log_q[i].last), 64'((i == 1) || (i >= 6)));

      // Random strobes at 50% density with occasional 1-5 cycle stalls.
      do_reset();
      strobes = 0;
      stall   = 0;
      cyc     = 0;
      while (strobes < 200 && cyc < 5000) begin
         logic sv;
         sv = 1'($urandom % 2);
         if (stall > 0) begin
            rdy = 1'b0;
            stall--;
         end else if (($urandom % 10) == 0) begin
            rdy   = 1'b0;
            stall = $urandom_range(5, 1) - 1;
         end else begin
            rdy = 1'b1;
         end
         step(sv, $urandom, 16'($urandom_range(6, 0)), rdy);
         if (sv) strobes++;
         cyc++;
      end
      check("t5_strobes", 64'(strobes), 64'd200);
      for (int i = 0; i < 40; i++) step(1'b0, '0, 16'd3, 1'b1);
      check("t5_empty", 64'(level), 64'd0);

      // Reset mid-frame with five beats buffered.
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b1, 32'hB0 + 32'(i), 16'd4, 1'b0);
      peek();
      check("t6_level", 64'(level), 64'd5);
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 32'hC0 + 32'(i), 16'd3, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 16'd3, 1'b1);
      check("t6_count", 64'(log_q.size()), 64'd3);
      for (int i = 0; i < 3 && i < log_q.size(); i++) begin
         check("t6_data", 64'(log_q[i].data), 64'(32'hC0 + 32'(i)));
         check("t6_last", 64'(log_q[i].last), 64'(i == 2));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/audio_frame_packetizer.md
# audio_frame_packetizer

Transmit-side source for the audio stream valid/ready/data/last interface. Accepts free-running ADC samples (strobe only, no backpressure), buffers them in a small FIFO, and emits them as fixed-length frames with `m_last` on the final beat of each frame. It sits between the sample capture front end and the skid buffer feeding the peak/RMS analyzer. It absorbs downstream stalls and reports samples lost to overflow.

## Interface
- `DATA_W`, 32: sample / beat width.
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `LEN_W`, 16: width of `frame_len`.

Ports:
- `clk`  in  1  single clock; all logic rising-edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `sample_valid`  in  1  one-cycle strobe; sample present this cycle.
- `sample_data`  in  DATA_W  sample value, qualified by `sample_valid`.
- `frame_len`  in  LEN_W  beats per frame; sampled at frame start.
- `m_valid`  out  1  beat available.
- `m_ready`  in  1  downstream accepts beat.
- `m_data`  out  DATA_W  beat payload.
- `m_last`  out  1  final beat of frame.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `overflow`  out  1  sticky: at least one sample dropped since reset.
- `ovf_count`  out  16  dropped-sample count; present only with `PACKETIZER_OVF_CNT_EN`.

## Operation
- The write side tracks a frame beat counter `wcnt` and a latched length `cur_len`.
  - On an accepted sample with `wcnt==0`, latch `cur_len = (frame_len==0) ? 1 : frame_len`.
  - Tag the stored beat with `last = (wcnt == cur_len_effective-1)`. `cur_len_effective` uses the value latched this same cycle when `wcnt==0`.
  - `wcnt` increments and wraps to 0 after the last beat.
- The `last` tag is stored in the FIFO alongside the data. A `frame_len` change only takes effect at the next frame boundary.
- Sample acceptance: a sample is accepted if `level < DEPTH`, or if a read handshake (`m_valid && m_ready`) occurs in the same cycle.
- Dropped samples:
  - Any sample arriving when not accepted is dropped.
  - A dropped sample is not counted in `wcnt`, so framing stays intact; frames contain only stored samples.
  - A drop sets `overflow` (sticky until reset).
- Read side: `m_valid = (level != 0)`. `m_data`/`m_last` come from the FIFO head entry.
  - Pop occurs on `m_valid && m_ready`.
  - While stalled (`m_valid && !m_ready`), `m_valid`, `m_data` and `m_last` hold stable.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally. `level` is a separate counter:
  - +1 on write only, −1 on read only.
  - Unchanged on simultaneous write and read.
- Reset mid-frame: everything clears asynchronously. Buffered beats are discarded, `wcnt=0`, and the next accepted sample starts a new frame. No partial-frame recovery.

## Timing
- Reset values: `m_valid=0`, `m_data=0`, `m_last=0`, `level=0`, `overflow=0`, `ovf_count=0`.
  - FIFO storage is not reset. `m_data`/`m_last` are forced to 0 when `level==0`.
- Latency: a sample accepted at edge N has `m_valid=1` with that data after edge N (visible in cycle N+1) when the FIFO was empty. There is no bypass path.
- Full with simultaneous read: the write is accepted and `level` stays at DEPTH. No drop occurs.
- Empty with simultaneous write: no read is possible; the beat appears the next cycle.
- `overflow` asserts in the cycle after the edge where the drop occurred.
- `m_ready` may toggle arbitrarily. `m_valid` never deasserts without a handshake.

## Configuration
- `PACKETIZER_OVF_CNT_EN` defined:
  - Port `ovf_count` exists.
  - It increments by 1 per dropped sample and saturates at 16'hFFFF.
- Undefined: the port and counter are absent. Only the sticky `overflow` flag is provided.

## Structure
- Shared package `audio_stream_pkg` holds:
  - `typedef struct packed { logic [DATA_W-1:0] data; logic last; } beat_t`
  - `OVF_CNT_W = 16`
- One sub-module, `sync_fifo`, holds beat_t storage, pointers and the level counter. It provides `wr_en`/`rd_en`/`full`/`empty`/`level` with the semantics above.
- The framing, acceptance and overflow logic lives in `audio_frame_packetizer`.

## Test plan
- `frame_len=3`, 7 strobes 0x10..0x16, `m_ready=1`:
  - Beats emerge in order, one cycle after each strobe.
  - `m_last` is set on 0x12 and 0x15. 0x16 is emitted with `m_last=0`.
- `frame_len=4`, `m_ready=0`, `DEPTH=16`, 20 strobes:
  - `level=16` and `overflow=1`, with `ovf_count=4` when enabled.
  - After `m_ready=1`, exactly 16 beats drain, with `m_last` on every 4th beat.
- FIFO full with a strobe in the same cycle as a handshake: no drop, `level` stays 16, `ovf_count` unchanged.
- Change `frame_len` from 2 to 5 mid-frame:
  - The current frame still ends after 2 beats.
  - The next frame is 5 beats long. `frame_len=0` yields `m_last` on every beat.
- Random `m_ready` stalls (10% probability, 1–5 cycles) over 200 strobes at 50% density:
  - The scoreboard matches every beat.
  - The stall-hold assertion never fires.
  - No X appears on `m_valid`/`m_last`.
- Assert `rst_n` with `level=5` mid-frame:
  - All outputs read 0 immediately.
  - After release, the first sample starts a new frame with `m_last` at position `frame_len`.
